// File: rtl/inst_rom_loader.sv
// Instruction ROM with a byte-stream loader: packs bytes big-endian into words,
// holds the core in reset while loading and serves combinational fetches once loaded.
module inst_rom_loader #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [31:0]           addr,
  output logic [31:0]           inst,
  input  logic                  ld_valid,
  input  logic [7:0]            ld_byte,
  input  logic                  ld_last,
  output logic                  ld_ready,
  output logic                  ld_done,
  output logic                  ld_err,
  output logic [DEPTH_LOG2:0]   ld_words,
  output logic                  core_rst_o
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_DONE,
    S_ERR
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [1:0]              r_byte_cnt;
  logic [23:0]             r_shift;
  logic [DEPTH_LOG2-1:0]   r_wr_ptr;
  logic [DEPTH_LOG2:0]     r_words;
  logic [31:0]             r_mem [2**DEPTH_LOG2];

  logic                    w_accept;
  logic                    w_fourth;
  logic                    w_in_range;
  logic [DEPTH_LOG2-1:0]   w_rd_idx;

  assign ld_ready   = rst & (r_state == S_LOAD);
  assign w_accept   = ld_valid & ld_ready;
  assign w_fourth   = w_accept & (r_byte_cnt == 2'd3);
  assign ld_done    = (r_state == S_DONE);
  assign ld_err     = (r_state == S_ERR);
  assign core_rst_o = (r_state != S_DONE);
  assign ld_words   = r_words;

  always_comb begin
    w_next = r_state;
    if (r_state == S_LOAD && w_accept) begin
      if (ld_last) begin
        w_next = w_fourth ? S_DONE : S_ERR;
      end else if (w_fourth && r_wr_ptr == '1) begin
        w_next = S_ERR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_LOAD;
      r_byte_cnt <= '0;
      r_shift    <= '0;
      r_wr_ptr   <= '0;
      r_words    <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        // shift keeps running past a word boundary; after three new bytes it is whole again
        r_byte_cnt <= r_byte_cnt + 2'd1;
        r_shift    <= {r_shift[15:0], ld_byte};
        if (w_fourth) begin
          r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
          r_words  <= r_words + (DEPTH_LOG2 + 1)'(1);
        end
      end
    end
  end

  // Memory has no reset so stale words survive a reload until overwritten
  always_ff @(posedge clk) begin
    if (w_fourth) begin
      r_mem[r_wr_ptr] <= {r_shift, ld_byte};
    end
  end

  assign w_rd_idx   = addr[DEPTH_LOG2+1:2];
  assign w_in_range = ((addr >> (DEPTH_LOG2 + 2)) == 32'd0);

  always_comb begin
    inst = '0;
    if (ce && r_state == S_DONE && w_in_range) begin
      inst = r_mem[w_rd_idx];
    end
  end

endmodule
